// File: rtl/calc_uart_pkg.sv
// Shared types for the calculator UART path: TX sequencer state encoding and byte width.
package calc_uart_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_START   = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_WAIT_LO = 3'd4,
      ST_NEXT    = 3'd5,
      ST_DONE    = 3'd6
   } tx_seq_state_t;
endpackage

// File: rtl/tx_timeout_counter.sv
// Counts cycles spent waiting for the UART core to acknowledge a start pulse.
// expired is high once the count reaches START_TIMEOUT-1.
module tx_timeout_counter #(
   parameter int START_TIMEOUT = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CW'(START_TIMEOUT - 1));

   // Saturate at the limit so the count can never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && !expired)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/tx_result_sequencer.sv
// Sends a latched multi-byte result through the shared UART TX core, LSB first,
// one tx_start per byte, with a timeout on the transmitter's busy acknowledge.
module tx_result_sequencer
   import calc_uart_pkg::*;
#(
   parameter int NUM_BYTES     = 2,
   parameter int START_TIMEOUT = 1000
) (
   input  logic                        CLK100MHZ,
   input  logic                        reset,
   input  logic                        trigger_tx,
   input  logic [BYTE_W*NUM_BYTES-1:0] result,
   input  logic                        tx_busy,
   output logic                        tx_start,
   output logic [BYTE_W-1:0]           tx_data,
   output logic                        seq_busy,
   output logic                        done,
   output logic                        err_timeout,
   output logic [2:0]                  c_state
);
   tx_seq_state_t               state_q, state_d;
   logic [BYTE_W*NUM_BYTES-1:0] shreg_q, shreg_d;
   logic [1:0]                  idx_q, idx_d;
   logic                        err_q, err_d;
   logic                        to_expired;

   tx_timeout_counter #(
      .START_TIMEOUT(START_TIMEOUT)
   ) u_timeout (
      .clk    (CLK100MHZ),
      .reset  (reset),
      .clear  (state_q == ST_START),
      .enable ((state_q == ST_WAIT_HI) && !tx_busy),
      .expired(to_expired)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (trigger_tx) begin
               shreg_d = result;
               idx_d   = 2'd0;
               err_d   = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD:    if (!tx_busy) state_d = ST_START;
         ST_START:   state_d = ST_WAIT_HI;
         ST_WAIT_HI: begin
            if (tx_busy)
               state_d = ST_WAIT_LO;
            else if (to_expired) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_LO: if (!tx_busy) state_d = ST_NEXT;
         ST_NEXT: begin
            if (idx_q == 2'(NUM_BYTES - 1))
               state_d = ST_DONE;
            else begin
               // Shift rather than index so the current byte always sits in the low lane.
               idx_d   = idx_q + 2'd1;
               shreg_d = shreg_q >> BYTE_W;
               state_d = ST_START;
            end
         end
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         idx_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign tx_start    = (state_q == ST_START);
   assign done        = (state_q == ST_DONE);
   assign seq_busy    = (state_q != ST_IDLE);
   assign tx_data     = shreg_q[BYTE_W-1:0];
   assign err_timeout = err_q;
   assign c_state     = state_q;
endmodule
